// File: rtl/w_writeback.sv
// W-stage write-back unit: latches M-stage results, extends load data and drives
// the register-file write port, forwarding values, retire counter and AdEL flag.
module w_writeback #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             M_Valid,
    input  logic             M_RFWr,
    input  logic [4:0]       M_A3,
    input  logic [2:0]       M_WDSel,
    input  logic [2:0]       M_LdType,
    input  logic [31:0]      M_ALUOut,
    input  logic [31:0]      M_DMRD,
    input  logic [31:0]      M_HILO,
    input  logic [31:0]      M_PC,
    output logic             RFWr,
    output logic [4:0]       A3,
    output logic [31:0]      WD,
    output logic [31:0]      PC,
    output logic             W_Valid,
    output logic             AdEL,
    output logic [CNT_W-1:0] RetireCnt
);

    logic             w_valid_reg;
    logic             rfwr_reg;
    logic [4:0]       a3_reg;
    logic [2:0]       wdsel_reg;
    logic [2:0]       ldtype_reg;
    logic [31:0]      aluout_reg;
    logic [31:0]      dmrd_reg;
    logic [31:0]      hilo_reg;
    logic [31:0]      pc_reg;
    logic [CNT_W-1:0] retire_cnt_reg;

    logic [7:0]  byte_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        is_lw;
    logic        is_lh;
    logic        adel;
    logic        retire;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            w_valid_reg    <= 1'b0;
            rfwr_reg       <= 1'b0;
            a3_reg         <= 5'd0;
            wdsel_reg      <= 3'd0;
            ldtype_reg     <= 3'd0;
            aluout_reg     <= 32'd0;
            dmrd_reg       <= 32'd0;
            hilo_reg       <= 32'd0;
            pc_reg         <= PC_RESET;
            retire_cnt_reg <= '0;
        end else begin
            if (Flush) begin
                w_valid_reg <= 1'b0;
                rfwr_reg    <= 1'b0;
                a3_reg      <= 5'd0;
                wdsel_reg   <= 3'd0;
                ldtype_reg  <= 3'd0;
                aluout_reg  <= 32'd0;
                dmrd_reg    <= 32'd0;
                hilo_reg    <= 32'd0;
                pc_reg      <= PC_RESET;
            end else if (!Stall) begin
                w_valid_reg <= M_Valid;
                rfwr_reg    <= M_RFWr;
                a3_reg      <= M_A3;
                wdsel_reg   <= M_WDSel;
                ldtype_reg  <= M_LdType;
                aluout_reg  <= M_ALUOut;
                dmrd_reg    <= M_DMRD;
                hilo_reg    <= M_HILO;
                pc_reg      <= M_PC;
            end
            if (retire) begin
                retire_cnt_reg <= retire_cnt_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = dmrd_reg[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = byte_lane[aluout_reg[1:0]];
    assign ld_half = aluout_reg[1] ? dmrd_reg[31:16] : dmrd_reg[15:0];

    always_comb begin
        ld_data = dmrd_reg;
        case (ldtype_reg)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'd0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = dmrd_reg;
        endcase
    end

    // Undefined load types behave as lw, so they take the word alignment rule.
    assign is_lh = (ldtype_reg == 3'd3) || (ldtype_reg == 3'd4);
    assign is_lw = !is_lh && (ldtype_reg != 3'd1) && (ldtype_reg != 3'd2);
    assign adel  = w_valid_reg && (wdsel_reg == 3'd1) &&
                   ((is_lw && (aluout_reg[1:0] != 2'd0)) || (is_lh && aluout_reg[0]));

    always_comb begin
        WD = 32'd0;
        if (w_valid_reg) begin
            case (wdsel_reg)
                3'd0:    WD = aluout_reg;
                3'd1:    WD = ld_data;
                3'd2:    WD = pc_reg + 32'd8;
                3'd3:    WD = hilo_reg;
                default: WD = 32'd0;
            endcase
        end
    end

    // A flush still lets the outgoing instruction count, even under stall.
    assign retire    = w_valid_reg && !adel && (Flush || !Stall);

    assign RFWr      = w_valid_reg && rfwr_reg && (a3_reg != 5'd0) && !adel;
    assign A3        = RFWr ? a3_reg : 5'd0;
    assign PC        = pc_reg;
    assign W_Valid   = w_valid_reg;
    assign AdEL      = adel;
    assign RetireCnt = retire_cnt_reg;

endmodule

// File: tb/tb_w_writeback.sv
// Directed bench for w_writeback; a narrow retire counter makes the wrap reachable.
module tb_w_writeback;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        M_Valid;
    logic        M_RFWr;
    logic [4:0]  M_A3;
    logic [2:0]  M_WDSel;
    logic [2:0]  M_LdType;
    logic [31:0] M_ALUOut;
    logic [31:0] M_DMRD;
    logic [31:0] M_HILO;
    logic [31:0] M_PC;
    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;
    logic        W_Valid;
    logic        AdEL;
    logic [3:0]  RetireCnt;

    int checks = 0;
    int errors = 0;

    w_writeback #(.PC_RESET(32'h0000_3000), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .M_Valid(M_Valid), .M_RFWr(M_RFWr), .M_A3(M_A3), .M_WDSel(M_WDSel),
        .M_LdType(M_LdType), .M_ALUOut(M_ALUOut), .M_DMRD(M_DMRD),
        .M_HILO(M_HILO), .M_PC(M_PC),
        .RFWr(RFWr), .A3(A3), .WD(WD), .PC(PC), .W_Valid(W_Valid),
        .AdEL(AdEL), .RetireCnt(RetireCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setm(input logic v, input logic wr, input logic [4:0] a3,
                        input logic [2:0] sel, input logic [2:0] ld,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] hl, input logic [31:0] pc);
        M_Valid = v; M_RFWr = wr; M_A3 = a3; M_WDSel = sel; M_LdType = ld;
        M_ALUOut = alu; M_DMRD = rd; M_HILO = hl; M_PC = pc;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        setm(1, 1, 5'd5, 3'd0, 3'd0, 32'h1234, 32'h0, 32'h0, 32'h3000);
        step(); step();
        chk("rst_rfwr", {31'd0, RFWr}, 32'd0);
        chk("rst_a3", {27'd0, A3}, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_pc", PC, 32'h3000);
        chk("rst_valid", {31'd0, W_Valid}, 32'd0);
        chk("rst_adel", {31'd0, AdEL}, 32'd0);
        chk("rst_cnt", {28'd0, RetireCnt}, 32'd0);
        Reset = 1'b1;

        setm(1, 1, 5'd5, 3'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h3000);
        step();
        chk("alu_wd", WD, 32'h1234_5678);
        chk("alu_rfwr", {31'd0, RFWr}, 32'd1);
        chk("alu_a3", {27'd0, A3}, 32'd5);
        chk("alu_cnt", {28'd0, RetireCnt}, 32'd0);
        $display("alu write   WD=%h A3=%0d cnt=%0d", WD, A3, RetireCnt);

        setm(1, 1, 5'd5, 3'd1, 3'd1, 32'h1003, 32'h80FF_1234, 32'h0, 32'h3004);
        step();
        chk("lb_wd", WD, 32'hFFFF_FF80);
        chk("lb_rfwr", {31'd0, RFWr}, 32'd1);
        chk("lb_cnt", {28'd0, RetireCnt}, 32'd1);
        $display("lb          WD=%h cnt=%0d", WD, RetireCnt);

        setm(1, 1, 5'd5, 3'd1, 3'd2, 32'h1003, 32'h80FF_1234, 32'h0, 32'h3008);
        step();
        chk("lbu_wd", WD, 32'h0000_0080);
        chk("lbu_cnt", {28'd0, RetireCnt}, 32'd2);
        $display("lbu         WD=%h cnt=%0d", WD, RetireCnt);

        setm(1, 1, 5'd6, 3'd1, 3'd0, 32'h1002, 32'h1111_2222, 32'h0, 32'h300C);
        step();
        chk("lw_adel", {31'd0, AdEL}, 32'd1);
        chk("lw_rfwr", {31'd0, RFWr}, 32'd0);
        chk("lw_a3", {27'd0, A3}, 32'd0);
        chk("lw_cnt", {28'd0, RetireCnt}, 32'd3);
        $display("lw misalign AdEL=%0d RFWr=%0d cnt=%0d", AdEL, RFWr, RetireCnt);

        setm(1, 1, 5'd6, 3'd1, 3'd4, 32'h1002, 32'hBEEF_0000, 32'h0, 32'h3010);
        step();
        chk("lhu_wd", WD, 32'h0000_BEEF);
        chk("lhu_adel", {31'd0, AdEL}, 32'd0);
        chk("lhu_cnt", {28'd0, RetireCnt}, 32'd3);
        $display("lhu         WD=%h cnt=%0d", WD, RetireCnt);

        setm(1, 1, 5'd6, 3'd1, 3'd3, 32'h1000, 32'h0000_8001, 32'h0, 32'h3014);
        step();
        chk("lh_wd", WD, 32'hFFFF_8001);
        chk("lh_cnt", {28'd0, RetireCnt}, 32'd4);
        $display("lh          WD=%h cnt=%0d", WD, RetireCnt);

        setm(1, 1, 5'd31, 3'd2, 3'd0, 32'h0, 32'h0, 32'h0, 32'h3004);
        step();
        chk("jal_wd", WD, 32'h0000_300C);
        chk("jal_a3", {27'd0, A3}, 32'd31);
        chk("jal_pc", PC, 32'h3004);
        chk("jal_cnt", {28'd0, RetireCnt}, 32'd5);
        $display("jal         WD=%h A3=%0d cnt=%0d", WD, A3, RetireCnt);

        setm(1, 1, 5'd0, 3'd0, 3'd0, 32'hAAAA, 32'h0, 32'h0, 32'h3018);
        step();
        chk("r0_rfwr", {31'd0, RFWr}, 32'd0);
        chk("r0_a3", {27'd0, A3}, 32'd0);
        chk("r0_cnt", {28'd0, RetireCnt}, 32'd6);
        $display("write $0    RFWr=%0d A3=%0d cnt=%0d", RFWr, A3, RetireCnt);

        setm(1, 1, 5'd7, 3'd3, 3'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h301C);
        step();
        chk("hilo_wd", WD, 32'hDEAD_BEEF);
        chk("hilo_cnt", {28'd0, RetireCnt}, 32'd7);
        $display("mfhi        WD=%h cnt=%0d", WD, RetireCnt);

        setm(1, 1, 5'd9, 3'd0, 3'd0, 32'h55, 32'h0, 32'h0, 32'h3020);
        step();
        chk("pre_stall_cnt", {28'd0, RetireCnt}, 32'd8);
        Stall = 1'b1;
        setm(1, 1, 5'd12, 3'd0, 3'd0, 32'h99, 32'h0, 32'h0, 32'h3024);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wd", WD, 32'h55);
            chk("stall_a3", {27'd0, A3}, 32'd9);
            chk("stall_cnt", {28'd0, RetireCnt}, 32'd8);
            $display("stall %0d     WD=%h A3=%0d cnt=%0d", i, WD, A3, RetireCnt);
        end
        Stall = 1'b0;
        setm(0, 0, 5'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("unstall_cnt", {28'd0, RetireCnt}, 32'd9);
        chk("bubble_wd", WD, 32'd0);
        chk("bubble_valid", {31'd0, W_Valid}, 32'd0);
        $display("unstall     cnt=%0d W_Valid=%0d", RetireCnt, W_Valid);

        setm(1, 1, 5'd3, 3'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h3028);
        step();
        chk("bubble_nocount", {28'd0, RetireCnt}, 32'd9);
        Flush = 1'b1; Stall = 1'b1;
        step();
        Flush = 1'b0; Stall = 1'b0;
        chk("flush_valid", {31'd0, W_Valid}, 32'd0);
        chk("flush_wd", WD, 32'd0);
        chk("flush_pc", PC, 32'h3000);
        chk("flush_cnt", {28'd0, RetireCnt}, 32'd10);
        $display("flush+stall W_Valid=%0d WD=%h cnt=%0d", W_Valid, WD, RetireCnt);

        for (int i = 0; i < 7; i++) begin
            setm(1, 1, 5'd2, 3'd0, 3'd0, 32'(i), 32'h0, 32'h0, 32'h4000);
            step();
            $display("retire %0d    cnt=%0d", i, RetireCnt);
        end
        chk("wrap_cnt", {28'd0, RetireCnt}, 32'd0);

        setm(1, 1, 5'd4, 3'd5, 3'd0, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'h4004);
        step();
        chk("bad_sel_wd", WD, 32'd0);
        chk("post_wrap_cnt", {28'd0, RetireCnt}, 32'd1);
        $display("wdsel=5     WD=%h cnt=%0d", WD, RetireCnt);

        #2;
        Reset = 1'b0;
        #1;
        chk("async_rfwr", {31'd0, RFWr}, 32'd0);
        chk("async_valid", {31'd0, W_Valid}, 32'd0);
        chk("async_pc", PC, 32'h3000);
        chk("async_cnt", {28'd0, RetireCnt}, 32'd0);
        $display("async reset RFWr=%0d PC=%h cnt=%0d", RFWr, PC, RetireCnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
